// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl
// Description : Drives the PC and ROM address. Fetched words go into a small
//               FIFO that feeds decode over valid/ready. Handles redirects,
//               halt and back-pressure.
//               Optional macro FETCH_HALT_ON_ILLEGAL_EN stops fetch on the
//               unmapped-ROM word.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en_i,
   output logic [31:0]                   addr_o,
   input  logic [31:0]                   instr_i,
   output logic [31:0]                   instr_o,
   output logic [31:0]                   pc_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   input  logic                          redirect_i,
   input  logic [31:0]                   redirect_pc_i,
   input  logic                          halt_i,
   output logic                          halt_o,
   output logic                          misalign_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] c_ptr_one = AW'(1);
   localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
   localparam logic [AW:0]   c_full    = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t         r_state;
   logic [31:0]    r_pc;
   logic [31:0]    r_mem_instr [FIFO_DEPTH];
   logic [31:0]    r_mem_pc    [FIFO_DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW:0]    r_count;
   logic           r_misalign;

   logic           w_full;
   logic           w_pop;
   logic           w_fetch;
   logic           w_illegal;
   logic           w_push;

   assign w_full  = (r_count == c_full);
   assign w_pop   = valid_o & ready_i;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign w_fetch = (r_state == S_RUN) & en_i & ~redirect_i & ~halt_i & (~w_full | w_pop);

`ifdef FETCH_HALT_ON_ILLEGAL_EN
   localparam logic [31:0] c_illegal = 32'hAAAA_AAAA;
   assign w_illegal = w_fetch & (instr_i == c_illegal);
`else
   assign w_illegal = 1'b0;
`endif

   assign w_push = w_fetch & ~w_illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_RUN;
         r_pc       <= RESET_PC;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= redirect_i & (|redirect_pc_i[1:0]);
         if (redirect_i) begin
            // A same-cycle pop is absorbed by the flush.
            r_state  <= S_RUN;
            r_pc     <= {redirect_pc_i[31:2], 2'b00};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + c_ptr_one;
               r_pc     <= r_pc + 32'd4;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + c_cnt_one;
               2'b01:   r_count <= r_count - c_cnt_one;
               default: r_count <= r_count;
            endcase
            if ((r_state == S_RUN) && (halt_i || w_illegal)) begin
               r_state <= S_HALT;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_instr[r_wr_ptr] <= instr_i;
         r_mem_pc[r_wr_ptr]    <= r_pc;
      end
   end

   assign addr_o     = r_pc;
   assign valid_o    = (r_count != '0);
   assign instr_o    = valid_o ? r_mem_instr[r_rd_ptr] : 32'h0;
   assign pc_o       = valid_o ? r_mem_pc[r_rd_ptr] : 32'h0;
   assign halt_o     = (r_state == S_HALT);
   assign misalign_o = r_misalign;
   assign level_o    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_ctrl
// Description : Directed and random stimulus for instr_fetch_ctrl, checked
//               against a queue-based reference model with a modelled ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst;
   logic        en_i;
   logic [31:0] addr_o;
   logic [31:0] instr_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        valid_o;
   logic        ready_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        halt_i;
   logic        halt_o;
   logic        misalign_o;
   logic [1:0]  level_o;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc;
   logic        m_halt;
   logic        m_mis;

   instr_fetch_ctrl #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en_i          (en_i),
      .addr_o        (addr_o),
      .instr_i       (instr_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .halt_i        (halt_i),
      .halt_o        (halt_o),
      .misalign_o    (misalign_o),
      .level_o       (level_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h00: return 32'h0150_0093;
         32'h04: return 32'h0010_0113;
         32'h08: return 32'h0020_8193;
         32'h0C: return 32'h0031_0233;
         32'h10: return 32'h0041_82B3;
         32'h14: return 32'h4052_0333;
         32'h18: return 32'h0063_23A3;
         32'h1C: return 32'h0020_1093;
         default: return 32'hAAAA_AAAA;
      endcase
   endfunction

   assign instr_i = rom_word(addr_o);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc   = 32'h0;
      m_halt = 1'b0;
      m_mis  = 1'b0;
   endtask

   task automatic check_all();
      logic        v;
      v = (m_q.size() != 0);
      check("addr_o",     addr_o,              m_pc);
      check("valid_o",    {31'h0, valid_o},    {31'h0, v});
      check("instr_o",    instr_o,             v ? m_q[0].ins : 32'h0);
      check("pc_o",       pc_o,                v ? m_q[0].pc  : 32'h0);
      check("level_o",    {30'h0, level_o},    32'(m_q.size()));
      check("halt_o",     {31'h0, halt_o},     {31'h0, m_halt});
      check("misalign_o", {31'h0, misalign_o}, {31'h0, m_mis});
   endtask

   // Advance the reference by one clock using the currently driven inputs.
   task automatic model_step();
      bit          pop;
      bit          room;
      logic [31:0] w;
      pop  = (m_q.size() != 0) && ready_i;
      room = (m_q.size() < DEPTH) || pop;
      if (redirect_i) begin
         m_q.delete();
         m_pc   = redirect_pc_i & 32'hFFFF_FFFC;
         m_halt = 1'b0;
         m_mis  = (redirect_pc_i[1:0] != 2'b00);
      end else begin
         m_mis = 1'b0;
         if (pop) void'(m_q.pop_front());
         if (!m_halt && en_i && !halt_i && room) begin
            w = rom_word(m_pc);
`ifdef FETCH_HALT_ON_ILLEGAL_EN
            if (w == 32'hAAAA_AAAA) begin
               m_halt = 1'b1;
            end else begin
               m_q.push_back('{pc: m_pc, ins: w});
               m_pc = m_pc + 32'd4;
            end
`else
            m_q.push_back('{pc: m_pc, ins: w});
            m_pc = m_pc + 32'd4;
`endif
         end
         if (halt_i) m_halt = 1'b1;
      end
   endtask

   task automatic cycle(input logic en, input logic rdy, input logic red,
                        input logic [31:0] rpc, input logic hlt);
      en_i          = en;
      ready_i       = rdy;
      redirect_i    = red;
      redirect_pc_i = rpc;
      halt_i        = hlt;
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst = 1'b1;
      en_i = 1'b1;
      ready_i = 1'b1;
      redirect_i = 1'b0;
      redirect_pc_i = 32'h0;
      halt_i = 1'b0;
      model_reset();
      #3;
      check_all();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all();

      // Free-running fetch with decode always ready.
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

      // Back-pressure fills the FIFO, then drains in order.
      cycle(1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

      // Misaligned redirect while full.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_001E, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

      // PC wrap at top of address space.
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

      // Halt with the FIFO holding entries, drain, then resume by redirect.
      cycle(1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

      // Enable low holds PC; redirect still lands.
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      // Asynchronous reset in mid-operation.
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;
      check_all();

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic        r_en;
         logic        r_rdy;
         logic        r_red;
         logic        r_hlt;
         logic [31:0] r_tgt;
         r_en  = ($urandom_range(0, 9) != 0);
         r_rdy = ($urandom_range(0, 9) < 7);
         r_red = ($urandom_range(0, 99) < 8);
         r_hlt = ($urandom_range(0, 99) < 5);
         r_tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 39));
         cycle(r_en, r_rdy, r_red, r_tgt, r_hlt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
